// File: rtl/port_controller.sv
// -----------------------------------------------------------------------------
// port_controller
//   I/O port decoder between the reduced-x86 CPU port bus and its peripherals.
//   Holds a PS/2 scancode FIFO (data 0x60, status 0x64), an 8-bit system
//   control register (0x61) and a free-running 16-bit tick counter (0x40/0x41).
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   port_addr     16-bit port address from the CPU
//   port_in       registered read data to the CPU
//   port_out      write data from the CPU
//   port_bit      access width: 0 = byte, 1 = word (bytes A and A+1)
//   port_clk      write strobe, acts on its rising edge
//   port_read     read strobe, acts on its rising edge
//   ps2_data      received PS/2 scancode
//   ps2_data_clk  scancode-valid strobe, acts on its rising edge
// -----------------------------------------------------------------------------
module port_controller #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] UNMAPPED   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] port_addr,
  output logic [15:0] port_in,
  input  logic [15:0] port_out,
  input  logic        port_bit,
  input  logic        port_clk,
  input  logic        port_read,
  input  logic [7:0]  ps2_data,
  input  logic        ps2_data_clk
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Strobe history for rising-edge detection
  logic port_clk_q, port_read_q, ps2_clk_q;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    sysctl_q, sysctl_d;
  logic [15:0]   tick_q, tick_d;
  logic [15:0]   port_in_q, port_in_d;

  logic        wr_ev, rd_ev, ps2_ev;
  logic        not_empty, full;
  logic        cover_data, cover_stat;
  logic        pop, push, ovf_set;
  logic [15:0] addr_hi;
  logic [7:0]  head_byte, status;

  // Byte-level read map; word reads call this for A and A+1.
  function automatic logic [7:0] decode_byte(
    input logic [15:0] a,
    input logic [7:0]  fifo_head,
    input logic [7:0]  stat,
    input logic [7:0]  sysctl,
    input logic [15:0] tick
  );
    case (a)
      16'h0060: decode_byte = fifo_head;
      16'h0064: decode_byte = stat;
      16'h0061: decode_byte = sysctl;
      16'h0040: decode_byte = tick[7:0];
      16'h0041: decode_byte = tick[15:8];
      default:  decode_byte = UNMAPPED;
    endcase
  endfunction

  assign wr_ev  = port_clk     & ~port_clk_q;
  assign rd_ev  = port_read    & ~port_read_q;
  assign ps2_ev = ps2_data_clk & ~ps2_clk_q;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign addr_hi   = port_addr + 16'd1;  // wraps 0xFFFF -> 0x0000
  assign head_byte = not_empty ? fifo_mem[head_q] : 8'h00;
  assign status    = {5'b0, ovf_q, full, not_empty};

  // A word access at A-1 also covers A
  assign cover_data = (port_addr == 16'h0060) || (port_bit && port_addr == 16'h005F);
  assign cover_stat = (port_addr == 16'h0064) || (port_bit && port_addr == 16'h0063);

  // A pop in the same cycle frees a slot, so a push alongside it is accepted
  // even when the FIFO is full.
  assign pop     = rd_ev && cover_data && not_empty;
  assign push    = ps2_ev && (!full || pop);
  assign ovf_set = ps2_ev && full && !pop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    sysctl_d  = sysctl_q;
    tick_d    = tick_q + 16'd1;
    port_in_d = {port_bit ? decode_byte(addr_hi, head_byte, status, sysctl_q, tick_q) : 8'h00,
                 decode_byte(port_addr, head_byte, status, sysctl_q, tick_q)};

    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Status read clears overflow after port_in samples it; a drop in the
    // same cycle is newer information and wins.
    if (rd_ev && cover_stat) ovf_d = 1'b0;
    if (ovf_set)             ovf_d = 1'b1;

    if (wr_ev) begin
      if (port_addr == 16'h0061)                  sysctl_d = port_out[7:0];
      else if (port_bit && port_addr == 16'h0060) sysctl_d = port_out[15:8];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      port_clk_q  <= 1'b0;
      port_read_q <= 1'b0;
      ps2_clk_q   <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      sysctl_q    <= 8'h00;
      tick_q      <= 16'h0000;
      port_in_q   <= 16'h0000;
    end else begin
      port_clk_q  <= port_clk;
      port_read_q <= port_read;
      ps2_clk_q   <= ps2_data_clk;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      sysctl_q    <= sysctl_d;
      tick_q      <= tick_d;
      port_in_q   <= port_in_d;
    end
  end

  // NOTE: the FIFO storage is not reset; count gates every read of it, and
  // leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail_q] <= ps2_data;
  end

  assign port_in = port_in_q;

endmodule

// File: tb/tb_port_controller.sv
module tb_port_controller;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] port_addr;
  logic [15:0] port_in;
  logic [15:0] port_out;
  logic        port_bit;
  logic        port_clk;
  logic        port_read;
  logic [7:0]  ps2_data;
  logic        ps2_data_clk;

  always #10 clk = ~clk;

  port_controller #(.FIFO_DEPTH(DEPTH), .UNMAPPED(8'hFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .port_addr    (port_addr),
    .port_in      (port_in),
    .port_out     (port_out),
    .port_bit     (port_bit),
    .port_clk     (port_clk),
    .port_read    (port_read),
    .ps2_data     (ps2_data),
    .ps2_data_clk (ps2_data_clk)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: scancode queue, sticky overflow, sysctl byte
  logic [7:0] m_q [$];
  logic       m_ovf;
  logic [7:0] m_sys;

  function automatic logic [7:0] m_byte(input logic [15:0] a);
    logic [7:0] r;
    case (a)
      16'h0060: r = (m_q.size() > 0) ? m_q[0] : 8'h00;
      16'h0064: r = {5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() > 0};
      16'h0061: r = m_sys;
      default:  r = 8'hFF;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_sys = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("reset_port_in", port_in, 16'h0000);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic push(input logic [7:0] b);
    if (m_q.size() == DEPTH) m_ovf = 1'b1;
    else                     m_q.push_back(b);
    ps2_data     = b;
    ps2_data_clk = 1'b1;
    step();
    ps2_data_clk = 1'b0;
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic w, input logic [15:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    if (a == 16'h0061)           m_sys = d[7:0];
    else if (w && a1 == 16'h0061) m_sys = d[15:8];
    port_addr = a;
    port_bit  = w;
    port_out  = d;
    port_clk  = 1'b1;
    step();
    port_clk = 1'b0;
    step();
  endtask

  // Read with model check; returns the observed value for extra literal checks
  task automatic rd(input string tag, input logic [15:0] a, input logic w,
                    output logic [15:0] v);
    logic [15:0] a1, e;
    a1 = a + 16'd1;
    e  = {w ? m_byte(a1) : 8'h00, m_byte(a)};
    if ((a == 16'h0060 || (w && a1 == 16'h0060)) && m_q.size() > 0) void'(m_q.pop_front());
    if (a == 16'h0064 || (w && a1 == 16'h0064)) m_ovf = 1'b0;
    port_addr = a;
    port_bit  = w;
    port_read = 1'b1;
    step();
    v = port_in;
    check(tag, v, e);
    port_read = 1'b0;
    step();
  endtask

  logic [15:0] v, t0, t1;
  logic [15:0] addr_tab [8];

  initial begin
    rst = 1'b1; port_addr = 16'h0060; port_out = '0; port_bit = 1'b0;
    port_clk = 1'b0; port_read = 1'b0; ps2_data = '0; ps2_data_clk = 1'b0;
    m_reset();
    addr_tab = '{16'h005F, 16'h0060, 16'h0061, 16'h0062,
                 16'h0063, 16'h0064, 16'h0070, 16'hFFFF};

    // Reset state
    do_reset();

    // Single scancode
    push(8'h82);
    rd("stat_one", 16'h0064, 1'b0, v);   check("stat_one_lit", v, 16'h0001);
    rd("data_82", 16'h0060, 1'b0, v);    check("data_82_lit", v, 16'h0082);
    rd("stat_empty", 16'h0064, 1'b0, v); check("stat_empty_lit", v, 16'h0000);

    // Overflow: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) push(8'(i));
    rd("stat_full_ovf", 16'h0064, 1'b0, v); check("stat_full_ovf_lit", v, 16'h0007);
    for (int i = 1; i <= 8; i++) begin
      rd("drain", 16'h0060, 1'b0, v);
      check("drain_lit", v, 16'(i));
    end
    rd("drain_empty", 16'h0060, 1'b0, v); check("drain_empty_lit", v, 16'h0000);
    rd("ovf_cleared", 16'h0064, 1'b0, v); check("ovf_cleared_lit", v, 16'h0000);

    // Word accesses, sysctl, unmapped, address wrap
    rd("word60_empty", 16'h0060, 1'b1, v); check("word60_empty_lit", v, 16'h0000);
    wr(16'h0061, 1'b1, 16'h1234);
    rd("sysctl", 16'h0061, 1'b0, v);       check("sysctl_lit", v, 16'h0034);
    rd("unmapped", 16'h0070, 1'b0, v);     check("unmapped_lit", v, 16'h00FF);
    rd("word60_sys", 16'h0060, 1'b1, v);   check("word60_sys_lit", v, 16'h3400);
    rd("word_wrap", 16'hFFFF, 1'b1, v);    check("word_wrap_lit", v, 16'hFFFF);
    wr(16'h0060, 1'b1, 16'hAB00);
    rd("sysctl_hi", 16'h0061, 1'b0, v);    check("sysctl_hi_lit", v, 16'h00AB);
    wr(16'h0064, 1'b0, 16'h00FF);
    rd("stat_nowrite", 16'h0064, 1'b0, v); check("stat_nowrite_lit", v, 16'h0000);

    // Read strobe held high for 5 cycles pops once
    push(8'h11);
    push(8'h22);
    port_addr = 16'h0060; port_bit = 1'b0; port_read = 1'b1;
    step();
    check("held_first", port_in, 16'h0011);
    void'(m_q.pop_front());
    repeat (4) step();
    port_read = 1'b0;
    step();
    rd("held_second", 16'h0060, 1'b0, v); check("held_second_lit", v, 16'h0022);
    rd("held_empty", 16'h0064, 1'b0, v);  check("held_empty_lit", v, 16'h0000);

    // Simultaneous push and pop with one entry queued
    push(8'hAA);
    ps2_data = 8'hBB; ps2_data_clk = 1'b1;
    port_addr = 16'h0060; port_bit = 1'b0; port_read = 1'b1;
    step();
    check("simul_data", port_in, 16'h00AA);
    void'(m_q.pop_front());
    m_q.push_back(8'hBB);
    ps2_data_clk = 1'b0; port_read = 1'b0;
    step();
    rd("simul_stat", 16'h0064, 1'b0, v); check("simul_stat_lit", v, 16'h0001);
    rd("simul_bb", 16'h0060, 1'b0, v);   check("simul_bb_lit", v, 16'h00BB);

    // Tick counter spacing
    port_addr = 16'h0040; port_bit = 1'b1;
    step();
    t0 = port_in;
    repeat (37) step();
    t1 = port_in;
    check("tick_diff_37", t1 - t0, 16'd37);
    t0 = port_in;
    repeat (1000) step();
    t1 = port_in;
    check("tick_diff_1000", t1 - t0, 16'd1000);

    // Randomised mix of pushes, reads and writes against the model
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [15:0] a;
      op = $urandom_range(0, 9);
      a  = addr_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) begin
        a = 16'($urandom);
        if (a >= 16'h003F && a <= 16'h0041) a = 16'h1234;
      end
      if (op < 5)      push(8'($urandom));
      else if (op < 8) rd("rand_read", a, 1'($urandom), v);
      else             wr(a, 1'($urandom), 16'($urandom));
    end
    rd("rand_final_stat", 16'h0064, 1'b0, v);

    // Reset in the middle of FIFO activity
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
    do_reset();
    rd("post_reset_stat", 16'h0064, 1'b0, v); check("post_reset_stat_lit", v, 16'h0000);
    rd("post_reset_data", 16'h0060, 1'b0, v); check("post_reset_data_lit", v, 16'h0000);
    rd("post_reset_sys", 16'h0061, 1'b0, v);  check("post_reset_sys_lit", v, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/port_controller.md
Name: port_controller

Overview:
- I/O port decoder/controller between the reduced-x86 CPU port bus and peripherals.
- Decodes the CPU's 16-bit port address.
- Returns read data and latches write data into internal registers.
- Buffers PS/2 scancodes in a FIFO exposed as ports 0x60/0x64; also holds a system-control register and a free-running tick counter.

Parameters:
- FIFO_DEPTH, 8, keyboard scancode FIFO entries (power of 2).
- UNMAPPED, 8'hFF, byte returned for reads of undecoded ports.

Ports:
- clk  input  1  system clock (50 MHz domain); all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- port_addr  input  16  port address from CPU.
- port_in  output  16  read data to CPU.
- port_out  input  16  write data from CPU.
- port_bit  input  1  access width: 0 = byte, 1 = word.
- port_clk  input  1  write strobe (level; action on 0→1 edge).
- port_read  input  1  read strobe (level; action on 0→1 edge).
- ps2_data  input  8  received PS/2 scancode.
- ps2_data_clk  input  1  scancode-valid strobe (action on 0→1 edge).

Behaviour:
- Edge detection: port_clk, port_read and ps2_data_clk are each registered once. An event fires in the cycle where the input is 1 and its registered copy is 0. A level held high fires exactly once.
- Byte map (read value for address A):
  - 0x60: FIFO head scancode, or 0x00 if the FIFO is empty.
  - 0x64: status. bit0 = FIFO not empty; bit1 = FIFO full; bit2 = overflow (sticky); bits7:3 = 0.
  - 0x61: sysctl register, 8 bits, read/write.
  - 0x40: tick[7:0].
  - 0x41: tick[15:8].
  - Any other address: UNMAPPED.
- port_in is registered, valid 1 cycle after port_addr/port_bit are stable.
  - Byte mode: port_in = {8'h00, byte(A)}.
  - Word mode: port_in = {byte(A+1), byte(A)}; A+1 wraps 0xFFFF→0x0000.
- Write event (port_clk edge):
  - Byte mode: byte(A) ← port_out[7:0].
  - Word mode: byte(A) ← port_out[7:0] and byte(A+1) ← port_out[15:8].
  - Only 0x61 is writable; writes to other addresses are ignored.
- Read event (port_read edge):
  - If the access covers 0x60 and the FIFO is not empty, pop one entry. Covers means A==0x60, or word mode with A==0x5F.
  - If the access covers 0x64, clear the overflow flag after the data is sampled.
  - port_in for that read reflects the pre-pop value.
- PS/2 event (ps2_data_clk edge): push ps2_data.
  - FIFO full: drop the byte and set overflow.
  - Simultaneous push and pop with the FIFO non-empty: both occur, count unchanged.
  - Simultaneous push and pop with the FIFO empty: push only, since there is nothing to pop.
- FIFO: circular buffer with head/tail pointers that wrap modulo FIFO_DEPTH, plus a count 0..FIFO_DEPTH. Full when count == FIFO_DEPTH.
- tick: 16-bit counter, +1 every clk, wraps 0xFFFF→0x0000.
- Reset state:
  - FIFO empty; pointers and count = 0.
  - overflow = 0; sysctl = 0x00; tick = 0x0000.
  - port_in = 16'h0000; edge-detect registers = 0.

Test Plan:
- Reset, then single-cycle pulse on ps2_data_clk with ps2_data=0x82; byte read of 0x64 → port_in=0x0001. Byte read of 0x60 → 0x0082. Re-read 0x64 → 0x0000.
- Push 9 scancodes 0x01..0x09 with no reads; read 0x64 → 0x0007. Then 8 reads of 0x60 → 0x01..0x08 in order. Next read of 0x60 → 0x0000. 0x64 → 0x0000 (overflow cleared by the earlier status read).
- Word write 0x1234 to 0x61 → read 0x61 byte = 0x0034. Word read at 0x60 with FIFO empty → 0x0000. Byte read of 0x70 → 0x00FF.
- Hold port_read high for 5 cycles at 0x60 with 2 entries queued → exactly one pop; a subsequent read returns the second entry.
- Simultaneous ps2_data_clk edge and 0x60 read edge with 1 entry (0xAA) queued, pushing 0xBB → port_in=0x00AA; FIFO holds 0xBB, count 1.
- Read 0x40 word twice N cycles apart → difference = N mod 65536. Reset asserted mid-FIFO operation → status 0x0000 on the next read.
